// File: rtl/led_shift_sched.sv
// LED shift-register sequencer: loads sw70 on a key press, then shifts/rotates it every DIV clocks.
// Optional KEY_DEBOUNCE_EN macro adds a DEB_CYC-cycle debounce on the synchronized key.
module led_shift_sched #(
   parameter int unsigned DIV     = 4,
   parameter int unsigned DIV_W   = 16,
   parameter int unsigned DEB_CYC = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] sw70,
   input  logic       key,
   input  logic [1:0] mode,
   input  logic       pause,
   output logic [7:0] led70,
   output logic       tick,
   output logic       busy,
   output logic       done
);

   if (DIV < 1 || DEB_CYC < 1 || (64'd1 << DIV_W) <= 64'(DIV)) begin : g_bad_param
      $error("led_shift_sched: invalid DIV/DIV_W/DEB_CYC");
   end

   typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

   localparam logic [DIV_W-1:0] CNT_LAST = DIV_W'(DIV - 1);

   state_t           state;
   logic [DIV_W-1:0] cnt;
   logic             k1, k2;
   logic             press;
   logic [7:0]       stepped;
   logic             zero_fill;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         k1 <= 1'b1;
         k2 <= 1'b1;
      end else begin
         k1 <= key;
         k2 <= k1;
      end
   end

`ifdef KEY_DEBOUNCE_EN
   localparam int unsigned DEB_W = (DEB_CYC < 2) ? 1 : $clog2(DEB_CYC + 1);
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);

   logic             kdb, kdb_q;
   logic [DEB_W-1:0] dcnt;

   // kdb only follows k2 after DEB_CYC consecutive cycles of disagreement
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         kdb   <= 1'b1;
         kdb_q <= 1'b1;
         dcnt  <= '0;
      end else begin
         kdb_q <= kdb;
         if (k2 == kdb) begin
            dcnt <= '0;
         end else if (dcnt == DEB_LAST) begin
            kdb  <= k2;
            dcnt <= '0;
         end else begin
            dcnt <= dcnt + DEB_W'(1);
         end
      end
   end

   assign press = kdb_q & ~kdb;
`else
   logic k3;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) k3 <= 1'b1;
      else     k3 <= k2;
   end

   assign press = k3 & ~k2;
`endif

   always_comb begin
      stepped = led70;
      case (mode)
         2'b00: stepped = {led70[6:0], 1'b0};
         2'b01: stepped = {1'b0, led70[7:1]};
         2'b10: stepped = {led70[6:0], led70[7]};
         2'b11: stepped = {led70[0], led70[7:1]};
         default: stepped = led70;
      endcase
   end

   assign zero_fill = ~mode[1];
   assign busy      = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         led70 <= '0;
         cnt   <= '0;
         tick  <= 1'b0;
         done  <= 1'b0;
      end else begin
         tick <= 1'b0;
         done <= 1'b0;
         if (press) begin
            // a load overrides any step falling due on the same edge
            led70 <= sw70;
            cnt   <= '0;
            state <= (sw70 != 8'h00) ? RUN : IDLE;
         end else begin
            case (state)
               IDLE: cnt <= '0;
               RUN: begin
                  if (pause) begin
                     state <= HOLD;
                  end else if (cnt == CNT_LAST) begin
                     cnt   <= '0;
                     led70 <= stepped;
                     tick  <= 1'b1;
                     if (zero_fill && stepped == 8'h00) begin
                        state <= IDLE;
                        done  <= 1'b1;
                     end
                  end else begin
                     cnt <= cnt + DIV_W'(1);
                  end
               end
               HOLD: if (!pause) state <= RUN;
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
